// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared state encoding and LED constants for the Stop It LED sequencer
package led_ctrl_pkg;
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      RUN     = 3'd2,
      STOPPED = 3'd3,
      BLINK   = 3'd4
   } state_e;
   localparam int LED_W = 16;
   localparam logic [LED_W-1:0] LEDS_FULL = '1;
endpackage

// File: rtl/tick_counter.sv
// tick_counter: free-running period counter that wraps at period_i-1 and flags the wrap cycle
module tick_counter #(
   parameter int W = 20
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] period_i,
   output logic         tick_o
);
   logic [W-1:0] cnt_q, cnt_d;
   assign tick_o = en_i && (cnt_q == period_i - W'(1));
   // clear wins, then wrap on terminal count, else count while enabled
   always_comb begin
      cnt_d = clr_i ? '0 : tick_o ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
   end
   // counter register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/led_shift_ctrl.sv
// led_shift_ctrl: sequences load/shift/off strobes of the 16-LED shifter for the Stop It game
module led_shift_ctrl import led_ctrl_pkg::*; #(
   parameter int TICK_W      = 20,
   parameter int BLINK_TICKS = 6
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              go_i,
   input  logic              stop_i,
   input  logic [TICK_W-1:0] period_i,
   input  logic [LED_W-1:0]  leds_i,
   output logic              load_o,
   output logic              shift_o,
   output logic              off_o,
   output logic [2:0]        state_o,
   output logic              lost_o
);
   localparam int BW = $clog2(BLINK_TICKS + 1);
   state_e            state_q, state_d;
   logic              load_q, load_d, shift_q, shift_d, off_q, off_d, lost_q, lost_d;
   logic [TICK_W-1:0] period_q, period_d, period_sat, cnt_period;
   logic [BW-1:0]     blink_q, blink_d;
   logic              tick, cnt_clr, cnt_en;
   // a zero period would never wrap, so it is treated as one
   assign period_sat = (period_i == '0) ? TICK_W'(1) : period_i;
   // during LOAD the counter already runs against the value being latched
   assign cnt_period = (state_q == LOAD) ? period_sat : period_q;
   assign cnt_clr    = go_i && (state_q inside {IDLE, STOPPED, BLINK});
   assign cnt_en     = state_q inside {LOAD, RUN, BLINK};
   tick_counter #(.W(TICK_W)) u_tick (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clr_i    (cnt_clr),
      .en_i     (cnt_en),
      .period_i (cnt_period),
      .tick_o   (tick)
   );
   // next state: stop beats a full bar in RUN, go beats everything elsewhere
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = go_i ? LOAD : IDLE;
         LOAD:    state_d = RUN;
         RUN:     state_d = stop_i ? STOPPED : (leds_i == LEDS_FULL) ? BLINK : RUN;
         STOPPED: state_d = go_i ? LOAD : STOPPED;
         BLINK:   state_d = go_i ? LOAD : (tick && blink_q == BW'(BLINK_TICKS - 1)) ? IDLE : BLINK;
         default: state_d = IDLE;
      endcase
   end
   // registered Moore outputs computed from the upcoming state and the tick
   always_comb begin
      load_d   = (state_d == LOAD);
      shift_d  = (state_d == RUN) && tick;
      blink_d  = (state_q == BLINK) ? blink_q + BW'(tick) : '0;
      off_d    = (state_d == IDLE) || ((state_d == BLINK) && ((state_q != BLINK) || (off_q ^ tick)));
      lost_d   = (state_d == BLINK) || (lost_q && (state_d != LOAD));
      period_d = (state_q == LOAD) ? period_sat : period_q;
   end
   // state, strobe and latched-period registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         load_q   <= 1'b0;
         shift_q  <= 1'b0;
         off_q    <= 1'b1;
         lost_q   <= 1'b0;
         period_q <= TICK_W'(1);
         blink_q  <= '0;
      end else begin
         state_q  <= state_d;
         load_q   <= load_d;
         shift_q  <= shift_d;
         off_q    <= off_d;
         lost_q   <= lost_d;
         period_q <= period_d;
         blink_q  <= blink_d;
      end
   end
   assign load_o  = load_q;
   assign shift_o = shift_q;
   assign off_o   = off_q;
   assign lost_o  = lost_q;
   assign state_o = state_q;
endmodule

// File: tb/tb_led_shift_ctrl.sv
// tb_led_shift_ctrl: directed bench with a cycle-level behavioural model and a shifter model
module tb_led_shift_ctrl;
   localparam int BLINK_TICKS = 6;
   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        go_i = 1'b0;
   logic        stop_i = 1'b0;
   logic [19:0] period_i = 20'd4;
   logic [15:0] leds = '0;
   logic [15:0] sw = '0;
   logic        load_o, shift_o, off_o, lost_o;
   logic [2:0]  state_o;
   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   led_shift_ctrl #(.TICK_W(20), .BLINK_TICKS(BLINK_TICKS)) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .go_i     (go_i),
      .stop_i   (stop_i),
      .period_i (period_i),
      .leds_i   (leds),
      .load_o   (load_o),
      .shift_o  (shift_o),
      .off_o    (off_o),
      .state_o  (state_o),
      .lost_o   (lost_o)
   );
   always #5 clk_i = ~clk_i;
   // shifter: load switches, or shift a one in from the right
   always @(posedge clk_i) leds <= load_o ? sw : shift_o ? {leds[14:0], 1'b1} : leds;
   // model: 0 idle, 1 load, 2 run, 3 stopped, 4 blink; el = cycles since LOAD while counting
   int   ms, mp, el, bt, p_now, nx, nbt;
   bit   tk, counting;
   logic e_load, e_shift, e_off, e_lost;
   always_comb begin
      counting = (ms == 1) || (ms == 2) || (ms == 4);
      p_now = (ms == 1) ? ((period_i == 0) ? 1 : int'(period_i)) : mp;
      tk = counting && ((el + 1) % p_now == 0);
      nx = ms;
      if (ms == 0 || ms == 3) nx = go_i ? 1 : ms;
      else if (ms == 1) nx = 2;
      else if (ms == 2) nx = stop_i ? 3 : (leds === 16'hFFFF) ? 4 : 2;
      else if (ms == 4) nx = go_i ? 1 : (tk && bt + 1 == BLINK_TICKS) ? 0 : 4;
      nbt = (ms == 4) ? bt + int'(tk) : 0;
   end
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ms <= 0; mp <= 1; el <= 0; bt <= 0;
         e_load <= 1'b0; e_shift <= 1'b0; e_off <= 1'b1; e_lost <= 1'b0;
      end else begin
         ms <= nx;
         mp <= (ms == 1) ? p_now : mp;
         el <= (nx == 1) ? 0 : counting ? el + 1 : el;
         bt <= nbt;
         e_load <= (nx == 1);
         e_shift <= (nx == 2) && tk;
         e_off <= (nx == 0) || ((nx == 4) && (nbt % 2 == 0));
         e_lost <= (nx == 4) || (e_lost && nx != 1);
      end
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask
   task automatic compare();
      chk("model_load", 32'(load_o), 32'(e_load));
      chk("model_shift", 32'(shift_o), 32'(e_shift));
      chk("model_off", 32'(off_o), 32'(e_off));
      chk("model_lost", 32'(lost_o), 32'(e_lost));
      chk("model_state", 32'(state_o), 32'(ms));
   endtask
   task automatic step(input logic g, input logic s);
      go_i = g;
      stop_i = s;
      @(posedge clk_i);
      #1;
      go_i = 1'b0;
      stop_i = 1'b0;
      @(negedge clk_i);
      cyc++;
      compare();
   endtask
   initial begin
      repeat (3) @(negedge clk_i);
      chk("rst_state", 32'(state_o), 0);
      chk("rst_off", 32'(off_o), 1);
      rst_ni = 1'b1;
      // idle: no strobes
      repeat (20) step(0, 0);
      chk("idle_state", 32'(state_o), 0);
      // basic run, P=4
      step(1, 0);
      chk("basic_load_c1", 32'(load_o), 1);
      for (int c = 2; c <= 14; c++) begin
         step(0, 0);
         chk("basic_load", 32'(load_o), 0);
         chk("basic_shift", 32'(shift_o), 32'(c == 5 || c == 9 || c == 13));
         if (c == 6) chk("basic_leds_1", 32'(leds), 32'h1);
         if (c == 10) chk("basic_leds_3", 32'(leds), 32'h3);
         if (c == 14) chk("basic_leds_7", 32'(leds), 32'h7);
      end
      // stop then restart with P=3, stop right before a shift
      step(0, 1);
      chk("stop_state", 32'(state_o), 3);
      period_i = 20'd3;
      step(1, 0);
      chk("p3_load", 32'(load_o), 1);
      for (int c = 2; c <= 6; c++) begin
         step(0, 0);
         chk("p3_shift", 32'(shift_o), 32'(c == 4));
      end
      chk("p3_leds", 32'(leds), 32'h1);
      step(0, 1);
      chk("stopped_noshift", 32'(shift_o), 0);
      chk("stopped_state", 32'(state_o), 3);
      for (int i = 0; i < 50; i++) begin
         step(0, i == 20);
         chk("stopped_leds", 32'(leds), 32'h1);
      end
      step(1, 0);
      chk("resume_load", 32'(load_o), 1);
      // go and stop together in RUN: stop wins
      step(0, 0);
      step(1, 1);
      chk("gostop_state", 32'(state_o), 3);
      // full bar with P=1
      period_i = 20'd1;
      sw = 16'h7FFF;
      step(1, 0);
      step(0, 0);
      chk("full_shift", 32'(shift_o), 1);
      chk("full_leds0", 32'(leds), 32'h7FFF);
      step(0, 0);
      chk("full_leds1", 32'(leds), 32'hFFFF);
      step(0, 0);
      chk("blink_state", 32'(state_o), 4);
      chk("blink_lost", 32'(lost_o), 1);
      chk("blink_off_c4", 32'(off_o), 1);
      for (int c = 5; c <= 9; c++) begin
         step(0, 0);
         chk("blink_off", 32'(off_o), 32'(c % 2 == 0));
         chk("blink_st", 32'(state_o), 4);
      end
      step(0, 0);
      chk("blink_done_state", 32'(state_o), 0);
      chk("blink_done_off", 32'(off_o), 1);
      chk("blink_done_lost", 32'(lost_o), 1);
      // period 0 behaves as 1
      period_i = 20'd0;
      sw = 16'h0;
      step(1, 0);
      chk("p0_lost_clr", 32'(lost_o), 0);
      for (int c = 2; c <= 5; c++) begin
         step(0, 0);
         chk("p0_shift", 32'(shift_o), 1);
      end
      step(0, 1);
      // go during BLINK with P=2
      period_i = 20'd2;
      sw = 16'h7FFF;
      step(1, 0);
      step(0, 0);
      step(0, 0);
      chk("p2_shift_c3", 32'(shift_o), 1);
      step(0, 0);
      chk("p2_leds_full", 32'(leds), 32'hFFFF);
      step(0, 0);
      chk("p2_blink", 32'(state_o), 4);
      chk("p2_lost", 32'(lost_o), 1);
      sw = 16'h0;
      step(1, 0);
      chk("abort_state", 32'(state_o), 1);
      chk("abort_load", 32'(load_o), 1);
      chk("abort_lost", 32'(lost_o), 0);
      // period change mid-run keeps the latched spacing
      for (int c = 7; c <= 14; c++) begin
         step(0, 0);
         if (c == 8) period_i = 20'd5;
         chk("pchg_shift", 32'(shift_o), 32'(c >= 8 && c % 2 == 0));
      end
      // asynchronous reset mid-run kills the pending strobe immediately
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_state", 32'(state_o), 0);
      chk("arst_off", 32'(off_o), 1);
      chk("arst_shift", 32'(shift_o), 0);
      chk("arst_load", 32'(load_o), 0);
      chk("arst_lost", 32'(lost_o), 0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (5) step(0, 0);
      chk("post_rst_state", 32'(state_o), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
